// File: rtl/alu_seq_if.sv
// Operation/result handshake bus between the decode stage and alu_seq.
// The master side issues operations and consumes results; the slave side is the ALU.
interface alu_seq_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] result_hi;
  logic             flag_c;
  logic             flag_f;
  logic             flag_l;
  logic             flag_n;
  logic             flag_z;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, result_hi,
    input  flag_c, flag_f, flag_l, flag_n, flag_z
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, result_hi,
    output flag_c, flag_f, flag_l, flag_n, flag_z
  );
endinterface

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshake, carry-chained ADDC and an iterative
// shift-add unsigned multiplier. Results and flags are held until consumed.
module alu_seq #(
  parameter int WIDTH = 16
) (
  input  logic     clk,
  input  logic     rst_n,
  alu_seq_if.slave bus
);

  localparam int MSB = WIDTH - 1;
  localparam int CW  = $clog2(WIDTH + 1);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_ADDU = 4'd1;
  localparam logic [3:0] OP_ADDC = 4'd2;
  localparam logic [3:0] OP_SUB  = 4'd3;
  localparam logic [3:0] OP_CMP  = 4'd4;
  localparam logic [3:0] OP_AND  = 4'd5;
  localparam logic [3:0] OP_OR   = 4'd6;
  localparam logic [3:0] OP_XOR  = 4'd7;
  localparam logic [3:0] OP_NOT  = 4'd8;
  localparam logic [3:0] OP_LSH  = 4'd9;
  localparam logic [3:0] OP_RSH  = 4'd10;
  localparam logic [3:0] OP_ARSH = 4'd11;
  localparam logic [3:0] OP_MULU = 4'd12;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_t;

  state_t               state_r;
  state_t               state_nxt_s;
  logic                 in_ready_s;
  logic                 accept_s;
  logic                 start_mul_s;
  logic                 mul_done_s;
  logic                 load_s;

  logic [WIDTH-1:0]     a_s;
  logic [WIDTH-1:0]     b_s;
  logic [3:0]           op_s;

  logic [WIDTH:0]       sum_s;
  logic [WIDTH:0]       addc_s;
  logic [WIDTH-1:0]     diff_s;
  logic                 lt_u_s;
  logic                 lt_s_s;
  logic                 shift_big_s;

  logic [WIDTH-1:0]     alu_res_s;
  logic                 fc_s;
  logic                 ff_s;
  logic                 fl_s;
  logic                 fn_s;
  logic                 fz_s;

  logic [CW-1:0]        cnt_r;
  logic [2*WIDTH-1:0]   mcand_r;
  logic [WIDTH-1:0]     mplier_r;
  logic [2*WIDTH-1:0]   acc_r;
  logic [2*WIDTH-1:0]   acc_nxt_s;

  logic [WIDTH-1:0]     load_res_s;
  logic [WIDTH-1:0]     load_hi_s;
  logic [4:0]           load_flags_s;

  logic                 out_valid_r;
  logic [WIDTH-1:0]     result_r;
  logic [WIDTH-1:0]     result_hi_r;
  logic [4:0]           flags_r;
  logic                 carry_r;

  assign a_s  = bus.a;
  assign b_s  = bus.b;
  assign op_s = bus.op;

  assign in_ready_s  = (state_r == IDLE) && (!out_valid_r || bus.out_ready);
  assign accept_s    = bus.in_valid && in_ready_s;
  assign start_mul_s = accept_s && (op_s == OP_MULU);
  assign load_s      = mul_done_s || (accept_s && (op_s != OP_MULU));

  assign sum_s       = {1'b0, a_s} + {1'b0, b_s};
  assign addc_s      = {1'b0, a_s} + {1'b0, b_s} + {{WIDTH{1'b0}}, carry_r};
  assign diff_s      = a_s - b_s;
  assign lt_u_s      = (a_s < b_s);
  assign lt_s_s      = ($signed(a_s) < $signed(b_s));
  assign shift_big_s = (b_s >= WIDTH'(WIDTH));
  assign acc_nxt_s   = acc_r + (mplier_r[0] ? mcand_r : {(2*WIDTH){1'b0}});

  // Single-cycle result and flags for every op except MULU; flags are {c,f,l,n,z}.
  always_comb begin
    alu_res_s = {WIDTH{1'b0}};
    fc_s      = 1'b0;
    ff_s      = 1'b0;
    fl_s      = 1'b0;
    fn_s      = 1'b0;
    fz_s      = 1'b0;
    case (op_s)
      OP_ADD: begin
        alu_res_s = sum_s[MSB:0];
        ff_s      = (a_s[MSB] == b_s[MSB]) && (sum_s[MSB] != a_s[MSB]);
        fn_s      = sum_s[MSB];
        fl_s      = lt_u_s;
        fz_s      = ~|sum_s[MSB:0];
      end
      OP_ADDU: begin
        alu_res_s = sum_s[MSB:0];
        fc_s      = sum_s[WIDTH];
        fl_s      = lt_u_s;
        fz_s      = ~|sum_s[MSB:0];
      end
      OP_ADDC: begin
        alu_res_s = addc_s[MSB:0];
        fc_s      = addc_s[WIDTH];
        fl_s      = lt_u_s;
        fz_s      = ~|addc_s;
      end
      OP_SUB: begin
        alu_res_s = diff_s;
        ff_s      = (a_s[MSB] != b_s[MSB]) && (diff_s[MSB] != a_s[MSB]);
        fn_s      = diff_s[MSB];
        fl_s      = lt_u_s;
        fz_s      = ~|diff_s;
      end
      OP_CMP: begin
        fn_s = lt_s_s;
        fl_s = lt_u_s;
        fz_s = (a_s == b_s);
      end
      OP_AND, OP_OR, OP_XOR: begin
        if (op_s == OP_AND) begin
          alu_res_s = a_s & b_s;
        end else if (op_s == OP_OR) begin
          alu_res_s = a_s | b_s;
        end else begin
          alu_res_s = a_s ^ b_s;
        end
        fn_s = alu_res_s[MSB];
        fl_s = lt_u_s;
        fz_s = ~|alu_res_s;
      end
      OP_NOT: begin
        alu_res_s = ~a_s;
        fn_s      = ~a_s[MSB];
        fz_s      = &a_s;
      end
      OP_LSH, OP_RSH, OP_ARSH: begin
        if (op_s == OP_LSH) begin
          alu_res_s = shift_big_s ? {WIDTH{1'b0}} : (a_s << b_s);
        end else if (op_s == OP_RSH) begin
          alu_res_s = shift_big_s ? {WIDTH{1'b0}} : (a_s >> b_s);
        end else begin
          alu_res_s = shift_big_s ? {WIDTH{a_s[MSB]}} : $unsigned($signed(a_s) >>> b_s);
        end
        fz_s = ~|alu_res_s;
      end
      default: begin
        alu_res_s = {WIDTH{1'b0}};
      end
    endcase
  end

  // Pick what gets registered: the finished product or the single-cycle result.
  always_comb begin
    if (mul_done_s) begin
      load_res_s   = acc_nxt_s[MSB:0];
      load_hi_s    = acc_nxt_s[2*WIDTH-1:WIDTH];
      load_flags_s = {(|acc_nxt_s[2*WIDTH-1:WIDTH]), 3'b000, (~|acc_nxt_s)};
    end else begin
      load_res_s   = alu_res_s;
      load_hi_s    = {WIDTH{1'b0}};
      load_flags_s = {fc_s, ff_s, fl_s, fn_s, fz_s};
    end
  end

  // Next-state logic: MUL runs WIDTH shift-add steps, the last one completes the op.
  always_comb begin
    state_nxt_s = state_r;
    mul_done_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (start_mul_s) begin
          state_nxt_s = MUL;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      MUL: begin
        if (cnt_r == CW'(WIDTH - 1)) begin
          state_nxt_s = IDLE;
          mul_done_s  = 1'b1;
        end else begin
          state_nxt_s = MUL;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Multiplier datapath: multiplicand shifts left, multiplier shifts right.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r    <= {CW{1'b0}};
      mcand_r  <= {(2*WIDTH){1'b0}};
      mplier_r <= {WIDTH{1'b0}};
      acc_r    <= {(2*WIDTH){1'b0}};
    end else if (start_mul_s) begin
      cnt_r    <= {CW{1'b0}};
      mcand_r  <= {{WIDTH{1'b0}}, a_s};
      mplier_r <= b_s;
      acc_r    <= {(2*WIDTH){1'b0}};
    end else if (mul_done_s) begin
      cnt_r    <= {CW{1'b0}};
      acc_r    <= acc_nxt_s;
    end else if (state_r == MUL) begin
      cnt_r    <= cnt_r + CW'(1);
      mcand_r  <= mcand_r << 1;
      mplier_r <= mplier_r >> 1;
      acc_r    <= acc_nxt_s;
    end
  end

  // Output registers and the chained carry; a new result wins over a same-edge drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      result_r    <= {WIDTH{1'b0}};
      result_hi_r <= {WIDTH{1'b0}};
      flags_r     <= 5'b00000;
      carry_r     <= 1'b0;
    end else if (load_s) begin
      out_valid_r <= 1'b1;
      result_r    <= load_res_s;
      result_hi_r <= load_hi_s;
      flags_r     <= load_flags_s;
      carry_r     <= load_flags_s[4];
    end else if (out_valid_r && bus.out_ready) begin
      out_valid_r <= 1'b0;
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_r;
  assign bus.result    = result_r;
  assign bus.result_hi = result_hi_r;
  assign bus.flag_c    = flags_r[4];
  assign bus.flag_f    = flags_r[3];
  assign bus.flag_l    = flags_r[2];
  assign bus.flag_n    = flags_r[1];
  assign bus.flag_z    = flags_r[0];

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed vector table, hand-written handshake and
// reset sequences, and randomized ops checked against an arithmetic reference model.
module tb_alu_seq;
  localparam int W = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   model_carry = 0;

  always #5 clk = ~clk;

  alu_seq_if #(.WIDTH(W)) bus ();
  alu_seq #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct packed {
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    logic [15:0] hi;
    logic [4:0]  fl;
    int          lat;
  } vec_t;

  typedef struct packed {
    logic [15:0] res;
    logic [15:0] hi;
    logic [4:0]  fl;
  } exp_t;

  vec_t tbl [15];

  function automatic vec_t mk(input int o, input int x, input int y, input int r,
                              input int h, input int f, input int l);
    vec_t v;
    v.op = 4'(o); v.a = 16'(x); v.b = 16'(y); v.res = 16'(r);
    v.hi = 16'(h); v.fl = 5'(f); v.lat = l;
    return v;
  endfunction

  // Reference model from the operation rules, using plain integer arithmetic.
  function automatic exp_t model(input int o, input int ua, input int ub, input int cin);
    exp_t e;
    int sa, sb, s, r;
    longint p;
    bit c, f, l, n, z;
    sa = (ua >= 32768) ? ua - 65536 : ua;
    sb = (ub >= 32768) ? ub - 65536 : ub;
    r = 0; p = 0; c = 0; f = 0; n = 0;
    l = (o <= 7) && (ua < ub);
    case (o)
      0: begin s = sa + sb; r = s & 65535; f = (s > 32767) || (s < -32768); n = r >= 32768; end
      1: begin s = ua + ub; r = s & 65535; c = s > 65535; end
      2: begin s = ua + ub + cin; r = s & 65535; c = s > 65535; end
      3: begin s = sa - sb; r = s & 65535; f = (s > 32767) || (s < -32768); n = r >= 32768; end
      4: begin r = 0; n = sa < sb; end
      5: begin r = ua & ub; n = r >= 32768; end
      6: begin r = ua | ub; n = r >= 32768; end
      7: begin r = ua ^ ub; n = r >= 32768; end
      8: begin r = 65535 - ua; n = r >= 32768; end
      9: r = (ub >= 16) ? 0 : ((ua << ub) & 65535);
      10: r = (ub >= 16) ? 0 : (ua >> ub);
      11: r = (sa >>> ((ub >= 16) ? 15 : ub)) & 65535;
      12: begin p = longint'(ua) * longint'(ub); r = int'(p & 65535); c = (p >> 16) != 0; end
      default: r = 0;
    endcase
    z = (r == 0);
    if (o == 2) z = (r == 0) && !c;
    if (o == 4) z = (ua == ub);
    if (o == 12) z = (p == 0);
    if (o >= 13) begin z = 0; l = 0; end
    e.res = r[15:0];
    e.hi  = (o == 12) ? 16'(p >> 16) : 16'h0000;
    e.fl  = {c, f, l, n, z};
    return e;
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, got, exp);
    end
  endtask

  function automatic logic [4:0] dut_flags();
    return {bus.flag_c, bus.flag_f, bus.flag_l, bus.flag_n, bus.flag_z};
  endfunction

  // Issue one op, wait for its result; returns edges from accept (inclusive) to out_valid.
  task automatic issue(input logic [3:0] o, input logic [15:0] x, input logic [15:0] y,
                       output int lat, output int rdy_hi);
    int guard;
    @(negedge clk);
    bus.op = o; bus.a = x; bus.b = y; bus.in_valid = 1'b1;
    guard = 0;
    while (!bus.in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!bus.in_ready) chk("accept_timeout", {63'd0, bus.in_ready}, 64'd1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    lat = 1; rdy_hi = 0; guard = 0;
    while (!bus.out_valid && guard < 100) begin
      if (bus.in_ready) rdy_hi++;
      @(posedge clk);
      #1;
      lat++;
      guard++;
    end
    if (!bus.out_valid) chk("result_timeout", {63'd0, bus.out_valid}, 64'd1);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat, rdy, stall, ov_seen;
    exp_t e;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    bus.op = 4'd0; bus.a = 16'h0000; bus.b = 16'h0000;

    tbl[0]  = mk(0,  'h7FFF, 'h0001, 'h8000, 'h0000, 'b01010, 1);
    tbl[1]  = mk(1,  'hFFFF, 'h0001, 'h0000, 'h0000, 'b10001, 1);
    tbl[2]  = mk(2,  'h0000, 'h0000, 'h0001, 'h0000, 'b00000, 1);
    tbl[3]  = mk(11, 'h8000, 20,     'hFFFF, 'h0000, 'b00000, 1);
    tbl[4]  = mk(10, 'h8000, 16,     'h0000, 'h0000, 'b00001, 1);
    tbl[5]  = mk(4,  'h0001, 'hFFFF, 'h0000, 'h0000, 'b00100, 1);
    tbl[6]  = mk(12, 'hFFFF, 'hFFFF, 'h0001, 'hFFFE, 'b10000, 17);
    tbl[7]  = mk(2,  'h0001, 'h0001, 'h0003, 'h0000, 'b00000, 1);
    tbl[8]  = mk(3,  'h8000, 'h0001, 'h7FFF, 'h0000, 'b01000, 1);
    tbl[9]  = mk(14, 'h0005, 'h0009, 'h0000, 'h0000, 'b00000, 1);
    tbl[10] = mk(8,  'hFFFF, 'h0000, 'h0000, 'h0000, 'b00001, 1);
    tbl[11] = mk(9,  'h0001, 15,     'h8000, 'h0000, 'b00000, 1);
    tbl[12] = mk(5,  'hF0F0, 'h0FF0, 'h00F0, 'h0000, 'b00000, 1);
    tbl[13] = mk(7,  'h1234, 'h1234, 'h0000, 'h0000, 'b00001, 1);
    tbl[14] = mk(2,  'hFFFF, 'h0001, 'h0000, 'h0000, 'b10000, 1);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("rst_result", {48'd0, bus.result}, 64'd0);
    chk("rst_result_hi", {48'd0, bus.result_hi}, 64'd0);
    chk("rst_flags", {59'd0, dut_flags()}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);

    // Directed vector table
    for (int i = 0; i < 15; i++) begin
      issue(tbl[i].op, tbl[i].a, tbl[i].b, lat, rdy);
      chk($sformatf("t%0d_result", i), {48'd0, bus.result}, {48'd0, tbl[i].res});
      chk($sformatf("t%0d_result_hi", i), {48'd0, bus.result_hi}, {48'd0, tbl[i].hi});
      chk($sformatf("t%0d_flags", i), {59'd0, dut_flags()}, {59'd0, tbl[i].fl});
      chk($sformatf("t%0d_latency", i), 64'(lat), 64'(tbl[i].lat));
      if (tbl[i].op == 4'd12) chk($sformatf("t%0d_ready_in_mul", i), 64'(rdy), 64'd0);
      model_carry = int'(tbl[i].fl[4]);
    end

    // Backpressure: held result, blocked second op, then same-edge accept and drain
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    issue(4'd0, 16'd1, 16'd2, lat, rdy);
    chk("bp_first_result", {48'd0, bus.result}, 64'd3);
    @(negedge clk);
    bus.op = 4'd0; bus.a = 16'd10; bus.b = 16'd20; bus.in_valid = 1'b1;
    #1 chk("bp_ready_low", {63'd0, bus.in_ready}, 64'd0);
    @(posedge clk);
    #1;
    chk("bp_hold_valid", {63'd0, bus.out_valid}, 64'd1);
    chk("bp_hold_result", {48'd0, bus.result}, 64'd3);
    @(negedge clk);
    bus.out_ready = 1'b1;
    #1 chk("bp_ready_high", {63'd0, bus.in_ready}, 64'd1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    chk("bp_second_valid", {63'd0, bus.out_valid}, 64'd1);
    chk("bp_second_result", {48'd0, bus.result}, 64'd30);
    model_carry = 0;

    // Randomized ops against the reference model, with occasional consumer stalls
    for (int k = 0; k < 300; k++) begin
      int o, x, y;
      o = int'($urandom_range(0, 15));
      x = int'($urandom_range(0, 65535));
      y = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 20)) : int'($urandom_range(0, 65535));
      if ($urandom_range(0, 7) == 0) y = x;
      e = model(o, x, y, model_carry);
      issue(4'(o), 16'(x), 16'(y), lat, rdy);
      chk($sformatf("r%0d_op%0d_result", k, o), {48'd0, bus.result}, {48'd0, e.res});
      chk($sformatf("r%0d_op%0d_result_hi", k, o), {48'd0, bus.result_hi}, {48'd0, e.hi});
      chk($sformatf("r%0d_op%0d_flags", k, o), {59'd0, dut_flags()}, {59'd0, e.fl});
      chk($sformatf("r%0d_op%0d_latency", k, o), 64'(lat), (o == 12) ? 64'd17 : 64'd1);
      if (o == 12) chk($sformatf("r%0d_ready_in_mul", k), 64'(rdy), 64'd0);
      model_carry = int'(e.fl[4]);
      if ($urandom_range(0, 5) == 0) begin
        bus.out_ready = 1'b0;
        stall = int'($urandom_range(1, 3));
        repeat (stall) @(posedge clk);
        #1;
        chk($sformatf("r%0d_stall_valid", k), {63'd0, bus.out_valid}, 64'd1);
        chk($sformatf("r%0d_stall_result", k), {48'd0, bus.result}, {48'd0, e.res});
        bus.out_ready = 1'b1;
      end
    end

    // Reset during the fifth multiply step aborts the product
    @(negedge clk);
    bus.op = 4'd12; bus.a = 16'h1234; bus.b = 16'h5678; bus.in_valid = 1'b1;
    #1 chk("abort_accept_ready", {63'd0, bus.in_ready}, 64'd1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_out_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("abort_result", {48'd0, bus.result}, 64'd0);
    chk("abort_result_hi", {48'd0, bus.result_hi}, 64'd0);
    chk("abort_flags", {59'd0, dut_flags()}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ov_seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1 if (bus.out_valid) ov_seen++;
    end
    chk("abort_no_result", 64'(ov_seen), 64'd0);
    issue(4'd2, 16'h0000, 16'h0000, lat, rdy);
    chk("post_rst_addc_result", {48'd0, bus.result}, 64'd0);
    chk("post_rst_addc_flags", {59'd0, dut_flags()}, 64'b00001);
    issue(4'd0, 16'd2, 16'd3, lat, rdy);
    chk("post_rst_add_result", {48'd0, bus.result}, 64'd5);
    chk("post_rst_add_flags", {59'd0, dut_flags()}, 64'b00100);
    chk("post_rst_add_latency", 64'(lat), 64'd1);

    @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, registered successor to the team's 16-bit combinational ALU. Accepts one operation per cycle over a valid/ready handshake, registers the result and the five status flags, and adds an iterative unsigned multiply. It also adds a carry register that chains ADDC operations across issues. Sits between the decode stage and register-file writeback; the flags feed the branch unit.

## Interface
- WIDTH, 16, operand/result width in bits; legal range 4 to 64.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operation presented
- in_ready  out  1  block can accept; combinational: state==IDLE && (!out_valid || out_ready)
- op  in  4  operation select
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B / shift amount (unsigned)
- out_valid  out  1  result registered and pending
- out_ready  in  1  consumer takes result
- result  out  WIDTH  result (low half for MULU)
- result_hi  out  WIDTH  MULU high half; 0 for all other ops
- flag_c, flag_f, flag_l, flag_n, flag_z  out  1 each  carry, signed overflow, unsigned low (a<b), negative, zero

## Operation
- Handshake: transfer on in_valid && in_ready, and likewise out_valid && out_ready. Operands and op are sampled only at the accept edge.
- Op encoding:
  - 0 ADD: signed add. f = signed overflow, n = result MSB, c = 0.
  - 1 ADDU: c = carry-out, f = 0, n = 0.
  - 2 ADDC: a + b + carry_q. c = carry-out. z = 1 only if result==0 and c==0.
  - 3 SUB: a - b. f = signed overflow of a+(~b+1), n = result MSB, c = 0.
  - 4 CMP: result 0. z = (a==b), n = signed a<b, l = unsigned a<b.
  - 5 AND, 6 OR, 7 XOR: n = result MSB.
  - 8 NOT: result ~a, n = result MSB.
  - 9 LSH, 10 RSH: logical shifts. A shift amount >= WIDTH gives 0.
  - 11 ARSH: arithmetic shift. A shift amount >= WIDTH gives all copies of a[WIDTH-1].
  - 12 MULU: unsigned a*b, 2*WIDTH-bit product as {result_hi, result}.
  - 13–15 NOP: result 0, all flags 0.
- Unless listed above: l = unsigned a<b for ops 0–7 and 0 for ops 8–15; z = (result==0); unlisted flags are 0.
- MULU flags: z = (full product == 0), c = (result_hi != 0), f/l/n = 0.
- carry_q: internal register loaded with the c of every completed op, including ops where c is forced to 0. It is read by ADDC at accept.
- FSM:
  - IDLE: accepting a non-MUL op registers result/flags and sets out_valid next edge; state stays IDLE. Accepting MULU loads the multiplicand, multiplier and a zero accumulator, clears the counter, and goes to MUL.
  - MUL: one shift-add step per cycle for WIDTH cycles. On the last step, register the product and flags, set out_valid, and return to IDLE.
- out_valid clears on an out_ready transfer unless a new result is registered on the same edge. Accept and output transfer on the same edge are legal: back-to-back results stream.
- Results and flags hold stable while out_valid && !out_ready.

## Timing
- Reset (async assert, sync-released by the system):
  - state = IDLE
  - out_valid, result, result_hi, all flags, carry_q, counter = 0
  - in_ready = 1 once rst_n is high
- Non-MUL latency: 1 cycle from the accept edge to out_valid. Throughput is 1 per cycle with out_ready held high.
- MULU latency: WIDTH+1 edges from accept to out_valid. in_ready = 0 throughout MUL.
- Backpressure: while out_valid && !out_ready, in_ready = 0 and no new op is accepted.
- Reset asserted mid-MUL aborts the operation: no result is issued, and the partial product is discarded.
- ADDC always sees the carry of the immediately preceding completed op. This holds because acceptance requires the previous result to be registered.
- No combinational path from a/b/op to any output; in_ready depends only on state, out_valid and out_ready.

## Test plan
- WIDTH=16: ADD a=0x7FFF b=0x0001 -> result 0x8000, f=1, n=1, z=0, c=0, one cycle after accept.
- ADDU 0xFFFF+0x0001 -> result 0x0000, c=1, z=1. Then ADDC 0x0000+0x0000 -> result 0x0001, c=0, z=0.
- MULU 0xFFFF*0xFFFF -> result_hi 0xFFFE, result 0x0001, c=1; out_valid exactly 17 edges after accept; in_ready low throughout.
- Backpressure: out_ready=0 after an ADD result, second op held with in_valid=1 -> in_ready=0 and result unchanged. Raise out_ready -> second op accepted on that edge, its result one cycle later.
- ARSH a=0x8000 b=20 -> 0xFFFF, z=0. RSH a=0x8000 b=16 -> 0x0000, z=1. CMP a=0x0001 b=0xFFFF -> l=1, n=0, z=0, result 0.
- Assert rst_n low at step 5 of a MULU -> out_valid stays 0, all outputs 0. After release, a fresh ADD 2+3 returns 5 normally.
